// File: rtl/math_pkg.sv
// rtl/math_pkg.sv - shared widths, stage records and log2 mantissa table for the math blocks
package math_pkg;

    localparam int LOG_W  = 12;
    localparam int LIN_W  = 34;
    localparam int FRAC_W = 6;
    localparam int LUT_W  = 13;
    localparam int EXP_W  = 6;
    localparam int MANT_W = 12;
    localparam int LUT_N  = 65;

    typedef struct packed {
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        logic              z;
    } s1_t;

    typedef struct packed {
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        logic              z;
    } s2_t;

    // L[k] = round(4096 * log2(1 + k/64)), k = 0..64
    localparam logic [LUT_W-1:0] LOG2_LUT [LUT_N] = '{
        13'd0,    13'd92,   13'd182,  13'd271,  13'd358,  13'd445,  13'd530,  13'd613,
        13'd696,  13'd778,  13'd858,  13'd937,  13'd1016, 13'd1093, 13'd1169, 13'd1244,
        13'd1319, 13'd1392, 13'd1465, 13'd1536, 13'd1607, 13'd1677, 13'd1746, 13'd1814,
        13'd1882, 13'd1949, 13'd2015, 13'd2080, 13'd2145, 13'd2208, 13'd2272, 13'd2334,
        13'd2396, 13'd2457, 13'd2518, 13'd2578, 13'd2637, 13'd2696, 13'd2754, 13'd2812,
        13'd2869, 13'd2926, 13'd2982, 13'd3037, 13'd3092, 13'd3146, 13'd3200, 13'd3254,
        13'd3307, 13'd3359, 13'd3412, 13'd3463, 13'd3514, 13'd3565, 13'd3615, 13'd3665,
        13'd3715, 13'd3764, 13'd3812, 13'd3861, 13'd3908, 13'd3956, 13'd4003, 13'd4050,
        13'd4096
    };

endpackage

// File: rtl/math_log2_lut.sv
// rtl/math_log2_lut.sv - registered dual-read log2 mantissa ROM returning L[i] and L[i+1]
module math_log2_lut
    import math_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [FRAC_W-1:0] idx_i,
    output logic [LUT_W-1:0]  lo_o,
    output logic [LUT_W-1:0]  hi_o
);

    logic [LUT_W-1:0] lo_q, lo_d;
    logic [LUT_W-1:0] hi_q, hi_d;

    // The upper neighbour index runs to 64, one past the 6-bit segment index.
    always_comb begin
        lo_d = LOG2_LUT[idx_i];
        hi_d = LOG2_LUT[{1'b0, idx_i} + 7'd1];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lo_q <= '0;
            hi_q <= '0;
        end else if (en_i) begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign lo_o = lo_q;
    assign hi_o = hi_q;

endmodule

// File: rtl/math_log2_34.sv
// rtl/math_log2_34.sv - 3-stage streaming converter from 34-bit linear to 6.6 log2 code
module math_log2_34
    import math_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LIN_W-1:0]  din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOG_W-1:0]  dout,
    output logic              zero
);

    logic              adv;
    logic              take;
    logic [LAT-1:0]    vld_q, vld_d;
    logic [EXP_W-1:0]  lod_e;
    s1_t               s1_q, s1_d;
    s2_t               s2_q, s2_d;
    logic [LUT_W-1:0]  l_lo, l_hi;
    logic [6:0]        seg_d;
    logic [LUT_W-1:0]  prod;
    logic [LUT_W-1:0]  p;
    logic [6:0]        r;
    logic [LOG_W-1:0]  dout_q, dout_d;
    logic              zero_q;

    // One advance signal moves every stage together, so a stall freezes the whole pipe.
    assign adv      = ena & (~vld_q[LAT-1] | out_ready);
    assign in_ready = rst_n & adv;
    assign take     = in_valid & in_ready;

    // Stage 1: leading-one position and the 12 bits just below it.
    always_comb begin
        lod_e = '0;
        for (int b = 0; b < LIN_W; b++) begin
            if (din[b]) begin
                lod_e = EXP_W'(b);
            end
        end
        s1_d.e = lod_e;
        s1_d.m = MANT_W'((din << (EXP_W'(LIN_W - 1) - lod_e)) >> (LIN_W - 1 - MANT_W));
        s1_d.z = (din == '0);
    end

    always_comb begin
        vld_d  = {vld_q[LAT-2:0], take};
        s2_d.e = s1_q.e;
        s2_d.f = s1_q.m[FRAC_W-1:0];
        s2_d.z = s1_q.z;
    end

    math_log2_lut u_lut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (adv),
        .idx_i   (s1_q.m[MANT_W-1:FRAC_W]),
        .lo_o    (l_lo),
        .hi_o    (l_hi)
    );

    // Stage 3: linear interpolation between neighbours, round to 1/64, add exponent.
    // r can reach 64, which carries cleanly into the integer field.
    always_comb begin
        seg_d  = 7'(l_hi - l_lo);
        prod   = LUT_W'(seg_d) * LUT_W'(s2_q.f);
        p      = l_lo + (prod >> FRAC_W);
        r      = 7'((p + LUT_W'(32)) >> FRAC_W);
        dout_d = s2_q.z ? '0 : ({s2_q.e, FRAC_W'(0)} + LOG_W'(r));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            dout_q <= '0;
            zero_q <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            dout_q <= dout_d;
            zero_q <= s2_q.z;
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign dout      = dout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_math_log2_34.sv
// tb/tb_math_log2_34.sv - scoreboard bench for the streaming log2 converter
module tb_math_log2_34;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] din;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] dout;
    logic        zero;

    typedef struct {
        logic [33:0] d;
        logic [11:0] exp_dout;
        logic        exp_zero;
        bit          exact;
        bit          lat;
        bit          rt;
        int          acc_cyc;
    } item_t;

    item_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    bit    knobs_on = 0;

    math_log2_34 #(.LAT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_log2(input logic [33:0] d);
        real v;
        if (d == 0) return 0;
        v = $ln(real'(d)) / $ln(2.0) * 64.0;
        return int'($floor(v + 0.5));
    endfunction

    function automatic logic [33:0] rnd_din();
        logic [63:0] r;
        logic [33:0] t;
        r = {$urandom, $urandom};
        t = r[63:30];
        return t >> $urandom_range(0, 33);
    endfunction

    // Present one sample, wait (bounded) for acceptance, log the expected result.
    task automatic send(input logic [33:0] d, input logic [11:0] e, input logic z,
                        input bit exact, input bit lat, input bit rt);
        item_t it;
        int    waits;
        bit    ok;
        in_valid = 1'b1;
        din      = d;
        waits    = 0;
        ok       = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            waits++;
            if (waits > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: din 0x%0h not taken in 200 cycles", d);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            it.d = d; it.exp_dout = e; it.exp_zero = z;
            it.exact = exact; it.lat = lat; it.rt = rt; it.acc_cyc = cyc;
            sb.push_back(it);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rnd(input bit lat);
        logic [33:0] d;
        d = rnd_din();
        send(d, 12'(ref_log2(d)), (d == 0), 1'b0, lat, 1'b0);
    endtask

    // Monitor: checks in_ready relation, stall hold, and pops the scoreboard on transfer.
    initial begin
        item_t       it;
        bit          hold_pend;
        logic [11:0] hold_dout;
        logic        hold_zero;
        int          diff;
        real         lin;
        hold_pend = 0;
        hold_dout = '0;
        hold_zero = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready_rel", 64'(in_ready), 64'(ena & (~out_valid | out_ready)));
                if (hold_pend) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_dout", 64'(dout), 64'(hold_dout));
                    chk("hold_zero", 64'(zero), 64'(hold_zero));
                end
                if (out_valid && out_ready && ena) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: dout 0x%0h with empty scoreboard", dout);
                    end else begin
                        it = sb.pop_front();
                        chk($sformatf("zero din=0x%0h", it.d), 64'(zero), 64'(it.exp_zero));
                        if (it.exact) begin
                            chk($sformatf("dout din=0x%0h", it.d), 64'(dout), 64'(it.exp_dout));
                        end else begin
                            diff = int'(dout) - int'(it.exp_dout);
                            n_vec++;
                            if (diff > 1 || diff < -1) begin
                                n_err++;
                                $display("FAIL dout_tol din=0x%0h: got %0d model %0d", it.d, dout, it.exp_dout);
                            end
                        end
                        if (it.lat) begin
                            chk($sformatf("latency din=0x%0h", it.d), 64'(cyc - it.acc_cyc), 64'd3);
                        end
                        if (it.rt) begin
                            lin = 2.0 ** (real'(dout) / 64.0);
                            n_vec++;
                            if (lin - real'(it.d) > 16.5 || real'(it.d) - lin > 16.5) begin
                                n_err++;
                                $display("FAIL round_trip: pow2(%0d) = %f required near %0d", dout, lin, it.d);
                            end
                        end
                    end
                end
                hold_pend = out_valid && !(out_ready && ena);
                hold_dout = dout;
                hold_zero = zero;
            end else begin
                hold_pend = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (knobs_on) begin
                ena       = ($urandom_range(0, 9) != 0);
                out_ready = ($urandom_range(0, 1) == 1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        rst_n = 1'b0; ena = 1'b1; out_ready = 1'b1; in_valid = 1'b0; din = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors with hand-derived codes
        send(34'd1,          12'h000, 1'b0, 1'b1, 1'b1, 1'b0);
        send(34'd2,          12'h040, 1'b0, 1'b1, 1'b1, 1'b0);
        send(34'd3,          12'h065, 1'b0, 1'b1, 1'b1, 1'b0);
        send(34'd256,        12'h200, 1'b0, 1'b1, 1'b1, 1'b0);
        send(34'd5,          12'd149, 1'b0, 1'b1, 1'b1, 1'b0);
        send(34'd0,          12'h000, 1'b1, 1'b1, 1'b1, 1'b0);
        send(34'h3_FFFF_FFFF, 12'h880, 1'b0, 1'b1, 1'b1, 1'b0);
        send(34'h2_0000_0000, 12'h840, 1'b0, 1'b1, 1'b1, 1'b0);
        send(34'd1000,       12'd638, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;

        // Back-to-back random stream, full throughput
        for (int i = 0; i < 1000; i++) send_rnd(1'b1);
        repeat (5) @(posedge clk);
        #1;

        // Random backpressure and clock-enable gaps
        knobs_on = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_rnd(1'b0);
        end
        knobs_on = 0;
        @(posedge clk);
        #1;
        ena = 1'b1;
        out_ready = 1'b1;
        waits = 0;
        while (sb.size() != 0 && waits < 200) begin
            @(posedge clk);
            waits++;
        end
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);

        // Reset with three samples in flight
        send(34'd7,  12'd180, 1'b0, 1'b1, 1'b0, 1'b0);
        send(34'd9,  12'd203, 1'b0, 1'b1, 1'b0, 1'b0);
        send(34'd11, 12'd221, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_dout", 64'(dout), 64'd0);
        @(posedge clk);
        #1;
        send(34'd4, 12'h080, 1'b0, 1'b1, 1'b1, 1'b0);
        waits = 0;
        while (sb.size() != 0 && waits < 50) begin
            @(posedge clk);
            waits++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk("final_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/math_log2_34.md
# math_log2_34

Pipelined fixed-point base-2 logarithm for the magnitude/power path. It converts a 34-bit unsigned linear value into a 12-bit log-domain code in 6.6 format, the same format math_pow2_12 accepts as input. It sits ahead of log-domain gain and threshold arithmetic, and ahead of math_pow2_12 when a value returns to linear. It is a streaming block with a valid/ready handshake, throughput 1 sample/cycle.

## Interface
Parameters:
- LAT, 3, pipeline depth; fixed, informational only.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; **synchronous, active-low**.
- ena  in  1  global clock enable; when low, all state holds.
- in_valid  in  1  din is valid.
- in_ready  out  1  block accepts din this cycle.
- din  in  34  unsigned linear value, integer code.
- out_valid  out  1  dout is valid.
- out_ready  in  1  downstream accepts dout.
- dout  out  12  log code: dout[11:6] = integer part, dout[5:0] = fraction (units of 1/64).
- zero  out  1  din was 0; dout is 0 for that sample.

## Operation
- Result: dout ≈ round(64·log2(din)). Error must be ≤1 LSB for all din ≥ 1.
- Stage 1, leading-one detect and normalize:
  - e = index of the most significant 1 in din (0..33).
  - m[11:0] = the 12 bits immediately below the leading one, zero-filled when e < 12.
  - z = (din == 0).
- Stage 2, LUT read: i = m[11:6]. Fetch L[i] and L[i+1], and carry forward f = m[5:0], e and z.
  - L[k] = round(4096·log2(1+k/64)) for k = 0..64.
  - L[0] = 0, L[32] = 2396, L[64] = 4096. Entries are 13 bits.
- Stage 3, interpolate and combine:
  - d = L[i+1] − L[i] (7 bits, ≤ 92).
  - p = L[i] + ((d·f) >> 6), range 0..4096.
  - r = (p + 32) >> 6, range 0..64.
  - dout = e·64 + r as a 12-bit add. A carry of r=64 rolls into the integer part; the maximum is 0x880, so no saturation is needed.
  - If z, force dout = 0 and zero = 1.
- Handshake:
  - adv = ena & (~out_valid | out_ready). All stage registers and valid bits shift only when adv is 1.
  - in_ready = adv. An input is taken when in_valid & in_ready.
  - Bubbles propagate as valid = 0.
- Outputs are stable while out_valid & ~out_ready (stall). No sample may be dropped or duplicated.

## Timing
- Latency is exactly 3 cycles from acceptance to out_valid when there is no stall and ena = 1.
- Sustained throughput is 1 sample/cycle with out_ready held high.
- Reset (rst_n = 0 at a clk edge):
  - All stage valids clear, so out_valid = 0.
  - dout = 0, zero = 0.
  - in_ready = 0 during the reset cycle and follows adv afterwards.
- Reset mid-stream discards all in-flight samples. The first post-reset output is the first sample accepted after reset.
- ena = 0 freezes everything, including out_valid and dout. in_ready is 0.
- Stall with ena = 1 and out_ready = 0 while out_valid = 1: the whole pipeline freezes and in_ready = 0.
- Simultaneous stall release and new input: the output drains and the input is accepted in the same cycle.

## Structure
- Shared package math_pkg:
  - widths: LOG_W = 12, LIN_W = 34, FRAC_W = 6, LUT_W = 13.
  - the 65-entry constant array LOG2_LUT, generated offline by script. Entries are not hand-typed.
- Sub-module math_log2_lut: registered dual-read ROM (L[i], L[i+1]) with ena/adv enable. It forms stage 2.
- Leading-one detect and normalize stay inline in the top level.

## Test plan
- Single samples, no backpressure:
  - din = 1 → dout 0x000.
  - din = 2 → 0x040.
  - din = 3 → 0x065 (101).
  - din = 256 → 0x200.
  - Each appears exactly 3 cycles after acceptance.
- Boundaries:
  - din = 0 → dout 0x000, zero = 1.
  - din = 2^34−1 → dout 0x880 (fraction carry into exponent), zero = 0.
  - din = 2^33 → 0x840.
- Back-to-back stream of 1000 random din with out_ready = 1:
  - one output per cycle, in order.
  - every result within ±1 of round(64·log2(din)) versus the reference model.
- Random out_ready (50%) and ena (90%) toggling:
  - no loss or duplication.
  - dout and zero stable during stall.
  - in_ready == ena & (~out_valid | out_ready) every cycle.
- rst_n pulsed low for 1 cycle with 3 samples in flight:
  - out_valid = 0 and dout = 0 next cycle.
  - no stale samples emerge.
  - the next accepted din = 4 yields 0x080 three cycles later.
- Round trip:
  - feed the dout of din = 1000 (expect 638) into math_pow2_12.
  - its linear result must match 1000 within the pow2 quantization bound.
